// File: rtl/simd_pkg.sv
// Shared types and constants for the result-unloader path.
// Memory geometry defaults match the processor core.
package simd_pkg;

  localparam int unsigned DMEM_DEPTH_DEF = 256;
  localparam int unsigned DATA_LEN_DEF   = 32;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } res_unl_state_t;

endpackage

// File: rtl/res_unloader_fifo.sv
// Small synchronous FIFO holding {last, data} beats for the unloader stream.
// Simultaneous push and pop leave the occupancy unchanged.
module res_unloader_fifo
  import simd_pkg::*;
#(
  parameter int unsigned Width = 33
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [Width-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [Width-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [Width-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wptr_q, rptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + FIFO_PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + FIFO_PTR_W'(1);
      end
      count_q <= count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/res_unloader.sv
// Streams len words of the result RAM out over valid/ready after a start trigger.
// Define RES_UNLOADER_CHECKSUM_EN to append an XOR checksum beat carrying m_last.
module res_unloader
  import simd_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEF,
  parameter int unsigned DATA_LEN   = DATA_LEN_DEF,
  parameter int unsigned RD_LAT     = 1,
  localparam int unsigned ADDR_W    = $clog2(DMEM_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W:0]     len_i,
  output logic                res_en_o,
  output logic [ADDR_W-1:0]   res_addr_o,
  input  logic [DATA_LEN-1:0] res_dout_i,
  output logic [DATA_LEN-1:0] m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                m_last_o,
  output logic                busy_o,
  output logic                done_o
);

  res_unl_state_t        state_q, state_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [RD_LAT-1:0]     rd_vld_q, rd_last_q;
  logic [FIFO_CNT_W-1:0] outst, fifo_count;
  logic                  credit_ok, issue, issue_last;
  logic                  data_push, data_last;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_LEN:0]     fifo_wdata, fifo_rdata;

  // Reads still travelling through the RAM pipeline.
  always_comb begin
    outst = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      outst = outst + FIFO_CNT_W'(rd_vld_q[i]);
    end
  end

  assign credit_ok  = ((FIFO_CNT_W + 1)'(outst) + (FIFO_CNT_W + 1)'(fifo_count))
                      < (FIFO_CNT_W + 1)'(FIFO_DEPTH);
  assign issue      = (state_q == StRead) && (len_q != '0) && credit_ok;
  assign issue_last = ({1'b0, addr_q} == (len_q - (ADDR_W + 1)'(1)));
  assign data_push  = rd_vld_q[RD_LAT-1];
  assign data_last  = rd_last_q[RD_LAT-1];
  assign fifo_pop   = m_valid_o && m_ready_i;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = len_i;
          addr_d  = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        // An empty run passes through here so done lands two cycles after start.
        if (len_q == '0) begin
          state_d = StDone;
        end else if (issue) begin
          if (issue_last) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        if (fifo_pop && fifo_rdata[DATA_LEN]) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      addr_q    <= '0;
      rd_vld_q  <= '0;
      rd_last_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      rd_vld_q[0]  <= issue;
      rd_last_q[0] <= issue && issue_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_last_q[i] <= rd_last_q[i-1];
      end
    end
  end

`ifdef RES_UNLOADER_CHECKSUM_EN
  logic [DATA_LEN-1:0] csum_q, csum_d;
  logic                csum_pend_q, csum_pend_d, csum_push;

  // Checksum beat follows the final data word once the FIFO has room.
  assign csum_push = csum_pend_q && !fifo_full;

  always_comb begin
    csum_d      = csum_q;
    csum_pend_d = csum_pend_q;
    if ((state_q == StIdle) && start_i) begin
      csum_d      = '0;
      csum_pend_d = 1'b0;
    end else begin
      if (data_push) begin
        csum_d = csum_q ^ res_dout_i;
        if (data_last) begin
          csum_pend_d = 1'b1;
        end
      end
      if (csum_push) begin
        csum_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q      <= '0;
      csum_pend_q <= 1'b0;
    end else begin
      csum_q      <= csum_d;
      csum_pend_q <= csum_pend_d;
    end
  end

  assign fifo_push  = data_push || csum_push;
  assign fifo_wdata = data_push ? {1'b0, res_dout_i} : {1'b1, csum_q};
`else
  assign fifo_push  = data_push;
  assign fifo_wdata = {data_last, res_dout_i};
`endif

  res_unloader_fifo #(
    .Width (DATA_LEN + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign res_en_o   = issue;
  assign res_addr_o = addr_q;
  assign m_valid_o  = !fifo_empty;
  assign m_data_o   = fifo_rdata[DATA_LEN-1:0];
  assign m_last_o   = fifo_rdata[DATA_LEN];
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_res_unloader.sv
// Scoreboard bench for res_unloader: two instances (RD_LAT 1 and 2) share stimulus.
// Honours RES_UNLOADER_CHECKSUM_EN in its reference model.
module tb_res_unloader;

`ifdef RES_UNLOADER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        start;
  logic [8:0]  len;
  logic        m_ready;

  logic        res_en   [2];
  logic [7:0]  res_addr [2];
  logic [31:0] dout     [2];
  logic [31:0] m_data   [2];
  logic        m_valid  [2];
  logic        m_last   [2];
  logic        busy     [2];
  logic        done     [2];

  logic [31:0] ram [256];
  logic [32:0] exp_q [2][$];
  int          beats    [2];
  int          done_cnt [2];
  int          cur_len;
  int          rmode;
  int          pat_idx;
  int          n_tests;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lat
    logic [31:0] p1, p2;
    int          cyc, issued, exp_addr;
    bit          armed, seen_valid, stall_q, hs_last_q;
    logic [32:0] prev_beat, exp_beat;

    res_unloader #(
      .DMEM_DEPTH (256),
      .DATA_LEN   (32),
      .RD_LAT     (g + 1)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rstn),
      .start_i    (start),
      .len_i      (len),
      .res_en_o   (res_en[g]),
      .res_addr_o (res_addr[g]),
      .res_dout_i (dout[g]),
      .m_data_o   (m_data[g]),
      .m_valid_o  (m_valid[g]),
      .m_ready_i  (m_ready),
      .m_last_o   (m_last[g]),
      .busy_o     (busy[g]),
      .done_o     (done[g])
    );

    // RAM model: data only valid for the enabled cycle's address, garbage otherwise.
    always @(posedge clk) begin
      p1 <= res_en[g] ? ram[res_addr[g]] : 32'hDEAD_BEEF;
      p2 <= p1;
    end
    assign dout[g] = (g == 0) ? p1 : p2;

    always @(negedge clk) begin
      if (!rstn) begin
        cyc = 0; issued = 0; exp_addr = 0; beats[g] = 0;
        armed = 0; seen_valid = 0; stall_q = 0; hs_last_q = 0;
      end else begin
        if (start && !busy[g]) begin
          cyc = 0; issued = 0; exp_addr = 0; beats[g] = 0;
          armed = 1; seen_valid = 0;
        end else begin
          cyc++;
        end
        if (stall_q)
          chk($sformatf("stable_lat%0d", g + 1), {m_valid[g], m_last[g], m_data[g]},
              {1'b1, prev_beat});
        if (res_en[g]) begin
          chk($sformatf("res_addr_lat%0d", g + 1), res_addr[g], exp_addr[7:0]);
          chk($sformatf("addr_in_range_lat%0d", g + 1), exp_addr < cur_len, 1);
          issued++;
          chk($sformatf("credit_lat%0d", g + 1), (issued - beats[g]) <= 4, 1);
          exp_addr++;
        end
        if (m_valid[g] && armed && !seen_valid) begin
          chk($sformatf("first_valid_cycle_lat%0d", g + 1), cyc, 3 + g);
          seen_valid = 1;
        end
        if (done[g]) begin
          if (cur_len == 0) chk($sformatf("done_len0_cycle_lat%0d", g + 1), cyc, 2);
          else chk($sformatf("done_after_last_lat%0d", g + 1), hs_last_q, 1);
          chk($sformatf("done_drained_lat%0d", g + 1), exp_q[g].size(), 0);
          done_cnt[g]++;
          armed = 0;
        end
        hs_last_q = 0;
        if (m_valid[g] && m_ready) begin
          if (exp_q[g].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat_lat%0d: got 0x%0h, expected no beat", g + 1,
                     {m_last[g], m_data[g]});
          end else begin
            exp_beat = exp_q[g].pop_front();
            chk($sformatf("beat_lat%0d", g + 1), {m_last[g], m_data[g]}, exp_beat);
          end
          beats[g]++;
          hs_last_q = m_last[g];
        end
        stall_q   = m_valid[g] && !m_ready;
        prev_beat = {m_last[g], m_data[g]};
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    m_ready = 1'b1;
    pat_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      pat_idx++;
      if (rmode == 0) m_ready = 1'b1;
      else if (rmode == 1) m_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
      else m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_expected(input int n);
    logic [31:0] x;
    x = '0;
    cur_len = n;
    for (int i = 0; i < n; i++) begin
      x ^= ram[i];
      for (int j = 0; j < 2; j++) exp_q[j].push_back({(i == n - 1) && !CsumEn, ram[i]});
    end
    if (CsumEn && n > 0)
      for (int j = 0; j < 2; j++) exp_q[j].push_back({1'b1, x});
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    len   = 9'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int n, input bit poke);
    int d0, d1, k;
    push_expected(n);
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    pulse_start(n);
    k = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && k < 3000) begin
      @(posedge clk);
      #1;
      start = poke && (k == 50);
      if (poke && k == 50) len = 9'd5;
      k++;
    end
    start = 1'b0;
    chk($sformatf("done_seen_len%0d", n), k < 3000, 1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle_after_done_%0d", i), {busy[i], done[i]}, 2'b00);
      chk($sformatf("queue_empty_%0d", i), exp_q[i].size(), 0);
      exp_q[i].delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_outputs_%0d", tag, i),
          {res_en[i], res_addr[i], m_valid[i], m_last[i], busy[i], done[i], m_data[i]}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    n_tests  = 0;
    n_fail   = 0;
    rmode    = 0;
    cur_len  = 0;
    start    = 1'b0;
    len      = '0;
    done_cnt = '{0, 0};
    beats    = '{0, 0};
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000 + i;
    rstn = 1'b0;
    #23;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    rmode = 0; run(16, 1'b0);
    rmode = 1; run(16, 1'b0);
    run(0, 1'b0);
    rmode = 0; run(256, 1'b1);
    rmode = 1; run(256, 1'b1);

    // Reset after five accepted beats, then a short clean run.
    push_expected(16);
    pulse_start(16);
    k = 0;
    while (beats[0] < 5 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_5_beats", k < 500, 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("midrun_reset_hold");
    exp_q[0].delete();
    exp_q[1].delete();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rmode = 0;
    run(3, 1'b0);

    ram[0] = 32'h1; ram[1] = 32'h2; ram[2] = 32'h4; ram[3] = 32'h8;
    run(4, 1'b0);

    rmode = 2;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) ram[i] = $urandom;
      run(int'($urandom_range(0, 80)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
